// File: rtl/gamepad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gamepad_pkg
//  Description : Shared constants for the gamepad button event block:
//                button bit positions, channel count, per-button FSM state
//                encoding, counter widths and default timing parameters.
//  Revision    : 1.0  initial release
// ============================================================================
package gamepad_pkg;

    // Channel count and button bit positions within btn_raw / btn_* vectors
    localparam int NUM_BTNS   = 12;
    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    // Counter widths
    localparam int DEB_CNT_W = 2;
    localparam int FRM_CNT_W = 6;

    // Default timing parameters (in frames) and auto-repeat mask (d-pad)
    localparam int                    DEF_DEBOUNCE_FRAMES = 2;
    localparam int                    DEF_REPEAT_DELAY    = 20;
    localparam int                    DEF_REPEAT_RATE     = 6;
    localparam logic [NUM_BTNS-1:0]   DEF_REPEAT_MASK     = 12'h0F0;

    // Per-button state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    // Saturating increment for the frame counter: sticks at all-ones
    function automatic logic [FRM_CNT_W-1:0] frm_sat_inc(input logic [FRM_CNT_W-1:0] v);
        logic [FRM_CNT_W-1:0] r;
        r = (v == {FRM_CNT_W{1'b1}}) ? v : v + 1'b1;
        return r;
    endfunction

endpackage : gamepad_pkg
`default_nettype wire

// File: rtl/gamepad_btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : gamepad_btn_channel
//  Description : One gamepad button: frame-sampled debounce, held level,
//                press/release pulses and optional auto-repeat.
//  Ports       : clk, rst_n (async, active-low), frame_tick (sample strobe),
//                btn_raw (raw level), present (pad connected),
//                repeat_en (auto-repeat allowed) ->
//                btn_held (debounced level), btn_press / btn_release
//                (one-clk pulses, registered)
//  Revision    : 1.0  initial release
// ============================================================================
module gamepad_btn_channel
    import gamepad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic btn_raw,
    input  logic present,
    input  logic repeat_en,
    output logic btn_held,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [DEB_CNT_W:0]   c_DEB_LIMIT = (DEB_CNT_W+1)'(DEBOUNCE_FRAMES);
    localparam logic [FRM_CNT_W-1:0] c_DELAY     = FRM_CNT_W'(REPEAT_DELAY);
    localparam logic [FRM_CNT_W-1:0] c_RATE      = FRM_CNT_W'(REPEAT_RATE);

    btn_state_e             state_q,   state_d;
    logic                   held_q,    held_d;
    logic                   press_q,   press_d;
    logic                   release_q, release_d;
    logic [DEB_CNT_W-1:0]   deb_q,     deb_d;
    logic [FRM_CNT_W-1:0]   frm_q,     frm_d;

    // One extra bit so the debounce increment can never wrap before compare
    logic [DEB_CNT_W:0]     w_deb_inc;
    logic [FRM_CNT_W-1:0]   w_frm_inc;
    logic                   w_accept;

    assign w_deb_inc = {1'b0, deb_q} + 1'b1;
    assign w_frm_inc = frm_sat_inc(frm_q);

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        deb_d     = deb_q;
        frm_d     = frm_q;
        w_accept  = 1'b0;

        if (!present) begin
            // Disconnected pad: silently forget everything, no release pulse
            state_d = ST_IDLE;
            held_d  = 1'b0;
            deb_d   = '0;
            frm_d   = '0;
        end else if (frame_tick) begin
            // Debounce: count consecutive ticks disagreeing with held level
            if (btn_raw != held_q) begin
                if (w_deb_inc >= c_DEB_LIMIT) begin
                    w_accept = 1'b1;
                    deb_d    = '0;
                end else begin
                    deb_d = w_deb_inc[DEB_CNT_W-1:0];
                end
            end else begin
                deb_d = '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        state_d = ST_HELD;
                        held_d  = 1'b1;
                        press_d = 1'b1;
                        frm_d   = '0;
                    end
                end
                ST_HELD: begin
                    // An accepted release takes priority over a due repeat
                    if (w_accept) begin
                        state_d   = ST_IDLE;
                        held_d    = 1'b0;
                        release_d = 1'b1;
                        frm_d     = '0;
                    end else if (repeat_en) begin
                        if (w_frm_inc >= c_DELAY) begin
                            state_d = ST_REPEAT;
                            press_d = 1'b1;
                            frm_d   = '0;
                        end else begin
                            frm_d = w_frm_inc;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (w_accept) begin
                        state_d   = ST_IDLE;
                        held_d    = 1'b0;
                        release_d = 1'b1;
                        frm_d     = '0;
                    end else if (w_frm_inc >= c_RATE) begin
                        press_d = 1'b1;
                        frm_d   = '0;
                    end else begin
                        frm_d = w_frm_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    held_d  = 1'b0;
                    frm_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            deb_q     <= '0;
            frm_q     <= '0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            deb_q     <= deb_d;
            frm_q     <= frm_d;
        end
    end

    assign btn_held    = held_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule : gamepad_btn_channel
`default_nettype wire

// File: rtl/gamepad_btn_events.sv
`default_nettype none
// ============================================================================
//  Module      : gamepad_btn_events
//  Description : Twelve independent button channels turning raw gamepad
//                levels into debounced levels, press pulses (with d-pad
//                auto-repeat) and release pulses, sampled once per frame.
//  Ports       : clk, rst_n (async, active-low), frame_tick (one-clk per
//                frame), btn_raw[11:0] {b,y,select,start,up,down,left,right,
//                a,x,l,r}, present -> btn_held[11:0], btn_press[11:0],
//                btn_release[11:0]
//  Revision    : 1.0  initial release
// ============================================================================
module gamepad_btn_events
    import gamepad_pkg::*;
#(
    parameter int                  DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int                  REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                  REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = DEF_REPEAT_MASK
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic [NUM_BTNS-1:0] btn_raw,
    input  logic                present,
    output logic [NUM_BTNS-1:0] btn_held,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        gamepad_btn_channel #(
            .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .frame_tick  (frame_tick),
            .btn_raw     (btn_raw[i]),
            .present     (present),
            .repeat_en   (REPEAT_MASK[i]),
            .btn_held    (btn_held[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule : gamepad_btn_events
`default_nettype wire

// File: tb/tb_gamepad_btn_events.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gamepad_btn_events
//  Description : Self-checking bench for gamepad_btn_events (default
//                parameters). Each frame tick pushes the expected outputs
//                for the following two clk cycles; a monitor pops and
//                compares them just after each rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gamepad_btn_events;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        frame_tick;
    logic [11:0] btn_raw;
    logic        present;
    logic [11:0] btn_held;
    logic [11:0] btn_press;
    logic [11:0] btn_release;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] raw;
        logic [11:0] gl;     // bits flipped on btn_raw between ticks only
        logic        pres;
        logic [11:0] held;
        logic [11:0] press;
        logic [11:0] rel;
        int          n;      // number of consecutive identical ticks
    } vec_t;

    typedef struct {
        logic [11:0] held;
        logic [11:0] press;
        logic [11:0] rel;
        int          tag;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    exp_t mon_e;

    gamepad_btn_events dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .btn_raw     (btn_raw),
        .present     (present),
        .btn_held    (btn_held),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({btn_held, btn_press, btn_release} !== {mon_e.held, mon_e.press, mon_e.rel}) begin
                failures++;
                $display("FAIL vec%0d held/press/release got %h/%h/%h expected %h/%h/%h",
                         mon_e.tag, btn_held, btn_press, btn_release,
                         mon_e.held, mon_e.press, mon_e.rel);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic [11:0] raw, input logic [11:0] gl,
                                input logic pres, input logic [11:0] held,
                                input logic [11:0] press, input logic [11:0] rel,
                                input int n);
        vec_t v;
        v.raw = raw; v.gl = gl; v.pres = pres;
        v.held = held; v.press = press; v.rel = rel; v.n = n;
        vecs.push_back(v);
    endfunction

    // One frame: tick cycle, then two quiet cycles. The cycle after the tick
    // must show the decision; the one after that must show pulses gone.
    task automatic drive_tick(input logic [11:0] raw, input logic [11:0] gl,
                              input logic pres, input logic [11:0] held,
                              input logic [11:0] press, input logic [11:0] rel,
                              input int tag);
        exp_t e;
        @(negedge clk);
        btn_raw    = raw;
        present    = pres;
        frame_tick = 1'b1;
        e.held = held; e.press = press; e.rel = rel; e.tag = tag;
        exp_q.push_back(e);
        e.press = 12'h000; e.rel = 12'h000;
        exp_q.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        btn_raw    = raw ^ gl;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        clk_en     = 1'b1;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        btn_raw    = 12'h000;
        present    = 1'b1;

        //   raw      gl       p   held     press    rel      n
        // a (bit 3, no repeat) held for 100+ ticks, then released
        add(12'h008, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h008, 12'h000, 1, 12'h008, 12'h008, 12'h000, 1);
        add(12'h008, 12'h000, 1, 12'h008, 12'h000, 12'h000, 100);
        add(12'h000, 12'h000, 1, 12'h008, 12'h000, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h008, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h000, 2);
        // left (bit 5) ticks 0..39 high: press @1, repeats @21,27,33,39
        add(12'h020, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h020, 12'h000, 1, 12'h020, 12'h020, 12'h000, 1);
        add(12'h020, 12'h000, 1, 12'h020, 12'h000, 12'h000, 19);
        add(12'h020, 12'h000, 1, 12'h020, 12'h020, 12'h000, 1);
        add(12'h020, 12'h000, 1, 12'h020, 12'h000, 12'h000, 5);
        add(12'h020, 12'h000, 1, 12'h020, 12'h020, 12'h000, 1);
        add(12'h020, 12'h000, 1, 12'h020, 12'h000, 12'h000, 5);
        add(12'h020, 12'h000, 1, 12'h020, 12'h020, 12'h000, 1);
        add(12'h020, 12'h000, 1, 12'h020, 12'h000, 12'h000, 5);
        add(12'h020, 12'h000, 1, 12'h020, 12'h020, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h020, 12'h000, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h020, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h000, 2);
        // one-tick glitch, then glitches only between ticks
        add(12'h008, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h000, 3);
        add(12'h000, 12'h008, 1, 12'h000, 12'h000, 12'h000, 3);
        // interrupted debounce restarts: high, low, high, high -> press
        add(12'h008, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h008, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h008, 12'h000, 1, 12'h008, 12'h008, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h008, 12'h000, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h008, 1);
        // up + b on the same tick
        add(12'h880, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h880, 12'h000, 1, 12'h880, 12'h880, 12'h000, 1);
        add(12'h880, 12'h000, 1, 12'h880, 12'h000, 12'h000, 5);
        add(12'h000, 12'h000, 1, 12'h880, 12'h000, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h880, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h000, 2);
        // start held, pad disconnected, reconnected still held
        add(12'h100, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h100, 12'h000, 1, 12'h100, 12'h100, 12'h000, 1);
        add(12'h100, 12'h000, 1, 12'h100, 12'h000, 12'h000, 3);
        add(12'h100, 12'h000, 0, 12'h000, 12'h000, 12'h000, 3);
        add(12'h100, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h100, 12'h000, 1, 12'h100, 12'h100, 12'h000, 1);
        add(12'h100, 12'h000, 1, 12'h100, 12'h000, 12'h000, 2);
        add(12'h000, 12'h000, 1, 12'h100, 12'h000, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h100, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h000, 2);
        // left released so that acceptance lands on the first-repeat tick (21)
        add(12'h020, 12'h000, 1, 12'h000, 12'h000, 12'h000, 1);
        add(12'h020, 12'h000, 1, 12'h020, 12'h020, 12'h000, 1);
        add(12'h020, 12'h000, 1, 12'h020, 12'h000, 12'h000, 18);
        add(12'h000, 12'h000, 1, 12'h020, 12'h000, 12'h000, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h020, 1);
        add(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h000, 2);

        // Reset state
        repeat (3) @(negedge clk);
        checks++;
        if ({btn_held, btn_press, btn_release} !== 36'h0) begin
            failures++;
            $display("FAIL reset_state got %h/%h/%h expected 000/000/000",
                     btn_held, btn_press, btn_release);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                drive_tick(vecs[i].raw, vecs[i].gl, vecs[i].pres,
                           vecs[i].held, vecs[i].press, vecs[i].rel, i);
            end
        end

        // Asynchronous reset mid-repeat with the clock stopped
        drive_tick(12'h020, 12'h000, 1, 12'h000, 12'h000, 12'h000, 100);
        drive_tick(12'h020, 12'h000, 1, 12'h020, 12'h020, 12'h000, 101);
        for (int k = 0; k < 19; k++)
            drive_tick(12'h020, 12'h000, 1, 12'h020, 12'h000, 12'h000, 102);
        drive_tick(12'h020, 12'h000, 1, 12'h020, 12'h020, 12'h000, 103);
        for (int k = 0; k < 5; k++)
            drive_tick(12'h020, 12'h000, 1, 12'h020, 12'h000, 12'h000, 104);
        begin : b_repeat_then_reset
            exp_t e;
            @(negedge clk);
            btn_raw    = 12'h020;
            frame_tick = 1'b1;
            e.held = 12'h020; e.press = 12'h020; e.rel = 12'h000; e.tag = 105;
            exp_q.push_back(e);
            @(negedge clk);
            frame_tick = 1'b0;
            clk_en     = 1'b0;
            #2;
            rst_n = 1'b0;
            #1;
            checks++;
            if ({btn_held, btn_press, btn_release} !== 36'h0) begin
                failures++;
                $display("FAIL async_reset got %h/%h/%h expected 000/000/000",
                         btn_held, btn_press, btn_release);
            end
            #20;
            rst_n = 1'b1;
            #3;
            clk_en = 1'b1;
        end
        drive_tick(12'h020, 12'h000, 1, 12'h000, 12'h000, 12'h000, 106);
        drive_tick(12'h020, 12'h000, 1, 12'h020, 12'h020, 12'h000, 107);
        drive_tick(12'h000, 12'h000, 1, 12'h020, 12'h000, 12'h000, 108);
        drive_tick(12'h000, 12'h000, 1, 12'h000, 12'h000, 12'h020, 109);

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gamepad_btn_events
`default_nettype wire
